// File: rtl/instruction_loader.sv
// ============================================================================
// instruction_loader: unpacks a framed byte stream into 9-bit words for the
// instruction memory write port and holds the core in reset until loaded.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [8:0]            wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  error,
  output logic                  core_hold
);

  localparam int          c_IW    = ADDR_WIDTH + 1;
  localparam logic [31:0] c_DEPTH = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_wr_en, w_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
  logic [8:0]            r_wr_data, w_wr_data;
  logic                  r_busy, r_load_done, r_error, r_core_hold;
  logic [15:0]           r_count, w_count;
  logic [7:0]            r_lo, w_lo;
  logic [c_IW-1:0]       r_index, w_index;
  logic                  w_xfer;
  logic [15:0]           w_len;
  logic                  w_last;

  assign in_ready = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                    (r_state == S_DATA_LO) || (r_state == S_DATA_HI);
  assign w_xfer   = in_valid && in_ready;
  assign w_len    = {in_data, r_count[7:0]};
  // Index is one bit wider than the address so a full DEPTH-word image fits.
  assign w_last   = (32'(r_index) + 32'd1) == 32'(r_count);

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_count     = r_count;
    w_lo        = r_lo;
    w_index     = r_index;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          w_count[7:0] = in_data;
          w_state_nxt  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          w_count = w_len;
          w_index = '0;
          if (w_len == 16'd0)             w_state_nxt = S_DONE;
          else if (32'(w_len) > c_DEPTH)  w_state_nxt = S_ERROR;
          else                            w_state_nxt = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (w_xfer) begin
          w_lo        = in_data;
          w_state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (w_xfer) begin
          if (in_data[7:1] != 7'd0) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_wr_en     = 1'b1;
            w_wr_addr   = r_index[ADDR_WIDTH-1:0];
            w_wr_data   = {in_data[0], r_lo};
            w_index     = r_index + c_IW'(1);
            w_state_nxt = w_last ? S_DONE : S_DATA_LO;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_error     <= 1'b0;
      r_core_hold <= 1'b1;
      r_count     <= '0;
      r_lo        <= '0;
      r_index     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_busy      <= (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                     (w_state_nxt == S_DATA_LO) || (w_state_nxt == S_DATA_HI);
      r_load_done <= (w_state_nxt == S_DONE);
      r_error     <= (w_state_nxt == S_ERROR);
      r_core_hold <= (w_state_nxt != S_DONE);
      r_count     <= w_count;
      r_lo        <= w_lo;
      r_index     <= w_index;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign load_done = r_load_done;
  assign error     = r_error;
  assign core_hold = r_core_hold;

endmodule

`default_nettype wire
